// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, between IF and the
// memory controller. Hits return in one cycle; misses issue a single word fetch.
module icache #(
  parameter int unsigned INDEX_BITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_flag,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_inst
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;

  typedef enum logic {S_IDLE, S_MISS} state_e;

  state_e               state_q;
  logic [LINES-1:0]     valid_q;
  logic [31:0]          data_q [LINES];
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic                 if_valid_q;
  logic [31:0]          if_inst_q;
  logic                 mem_req_q;
  logic [31:0]          mem_addr_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  hit;
  logic                  accept;
  logic                  fill;
  logic                  pc_lsb_unused;

  assign req_idx  = if_pc[INDEX_BITS+1:2];
  assign req_tag  = if_pc[31:INDEX_BITS+2];
  // The outstanding miss address doubles as the latched index/tag.
  assign miss_idx = mem_addr_q[INDEX_BITS+1:2];
  assign miss_tag = mem_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign if_ready = (state_q == S_IDLE);
  assign accept   = if_req && if_ready && rdy && !jump_wrong_flag;
  assign fill     = rdy && (state_q == S_MISS) && mem_done;
  assign pc_lsb_unused = ^if_pc[1:0];

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // Tag/data arrays: written on every fill, including one that races a flush.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[miss_idx] <= mem_inst;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

  // Control FSM with registered outputs; priority rst > !rdy > flush > fill > accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'h0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
    end else if (rdy) begin
      if_valid_q <= 1'b0;
      if (fill) begin
        valid_q[miss_idx] <= 1'b1;
      end
      if (jump_wrong_flag) begin
        mem_req_q <= 1'b0;
        state_q   <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              if (hit) begin
                if_valid_q <= 1'b1;
                if_inst_q  <= data_q[req_idx];
              end else begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= {if_pc[31:2], 2'b00};
                state_q    <= S_MISS;
              end
            end
          end
          S_MISS: begin
            if (mem_done) begin
              if_valid_q <= 1'b1;
              if_inst_q  <= mem_inst;
              mem_req_q  <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
